// File: rtl/serial_hexload_if.sv
// Handshake bundle between uart_rx text input, the hex parser and the binary consumer.
interface serial_hexload_if #(
  parameter int COUNT_BITS = 16
);
  logic [7:0]            in_data;
  logic                  in_strobe;
  logic [7:0]            out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  error_strobe;
  logic                  overflow;
  logic [COUNT_BITS-1:0] count;

  modport slave (
    input  in_data, in_strobe, out_ready,
    output out_data, out_valid, error_strobe, overflow, count
  );

  modport master (
    output in_data, in_strobe, out_ready,
    input  out_data, out_valid, error_strobe, overflow, count
  );
endinterface

// File: rtl/serial_hexload.sv
// ASCII hex text to binary byte parser: two digits per byte, whitespace
// separators, '#' comments to end of line, one-entry output holding register.
module serial_hexload #(
  parameter int COUNT_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  serial_hexload_if.slave  bus
);

  typedef enum logic [1:0] {HI, LO, COMMENT} state_t;

  state_t     state;
  logic [3:0] nibble;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ||
           (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  // Letters 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

  function automatic logic is_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0D) || (c == 8'h0A);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= HI;
      nibble           <= 4'd0;
      bus.out_data     <= 8'd0;
      bus.out_valid    <= 1'b0;
      bus.error_strobe <= 1'b0;
      bus.overflow     <= 1'b0;
      bus.count        <= '0;
    end else begin
      bus.error_strobe <= 1'b0;
      if (bus.out_valid && bus.out_ready)
        bus.out_valid <= 1'b0;

      if (bus.in_strobe) begin
        unique case (state)
          HI: begin
            if (is_hex(bus.in_data)) begin
              nibble <= hex_val(bus.in_data);
              state  <= LO;
            end else if (bus.in_data == 8'h23) begin
              state <= COMMENT;
            end else if (!is_ws(bus.in_data)) begin
              bus.error_strobe <= 1'b1;
            end
          end
          LO: begin
            if (is_hex(bus.in_data)) begin
              state <= HI;
              // A byte consumed this same edge frees the slot for the new one.
              if (!bus.out_valid || bus.out_ready) begin
                bus.out_data  <= {nibble, hex_val(bus.in_data)};
                bus.out_valid <= 1'b1;
                bus.count     <= bus.count + COUNT_BITS'(1);
              end else begin
                bus.overflow     <= 1'b1;
                bus.error_strobe <= 1'b1;
              end
            end else begin
              bus.error_strobe <= 1'b1;
              nibble           <= 4'd0;
              state            <= (bus.in_data == 8'h23) ? COMMENT : HI;
            end
          end
          COMMENT: begin
            if (bus.in_data == 8'h0A || bus.in_data == 8'h0D)
              state <= HI;
          end
          default: state <= HI;
        endcase
      end
    end
  end

endmodule
